pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have one clock and a synchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, synchronous active-low reset.
REQ-003 SHALL have PCSource input 2: 0 = sequential, 1 = branch, 2 = jump, 3 = reserved (treated as 0).
REQ-004 SHALL have PC_branch input 32, the branch target.
REQ-005 SHALL have PC_jump input 32, the jump target.
REQ-006 SHALL have Stall input 1, the hazard-unit hold request for IF/ID.
REQ-007 SHALL have IMemReq output 1, the instruction-memory request.
REQ-008 SHALL have IMemAddr output 32, the fetch address.
REQ-009 SHALL have IMemReady input 1, access complete; IMemData is valid in the same cycle.
REQ-010 SHALL have IMemData input 32, the fetched word.
REQ-011 SHALL have Instr_ID output 32, the IF/ID instruction.
REQ-012 SHALL have PC_plus4_ID output 32, the IF/ID value of fetch PC + 4.
REQ-013 SHALL have Valid_ID output 1, meaning the IF/ID contents are a real instruction.
REQ-014 SHALL have FetchCount output 32 and FlushCount output 32, the performance counters (see Configuration).

Function
REQ-015 SHALL treat PCSource 1 or 2 as a redirect to PC_branch or PC_jump respectively, with bits [1:0] forced to 00; the redirect is sampled in any cycle.
REQ-016 SHALL implement FSM states FETCH, DISCARD and HOLD.
REQ-017 SHALL drive IMemReq=1 in FETCH and DISCARD and 0 in HOLD.
REQ-018 SHALL hold IMemAddr stable until IMemReady.
REQ-019 SHALL drive IMemAddr = PC in FETCH and HOLD, and the old address in DISCARD.
REQ-020 SHALL, in FETCH with ready, !Stall and no redirect: Instr_ID<=IMemData; PC_plus4_ID<=PC+4; Valid_ID<=1; PC<=PC+4; stay in FETCH.
REQ-021 SHALL, in FETCH with !ready, !Stall and no redirect: Valid_ID<=0 (bubble); PC holds.
REQ-022 SHALL, in FETCH with ready and Stall: capture IMemData into a hold buffer; IF/ID holds; next state HOLD.
REQ-023 SHALL, in HOLD with Stall: hold everything.
REQ-024 SHALL, in HOLD with !Stall: move the buffer into IF/ID with Valid_ID<=1; PC<=PC+4; next state FETCH.
REQ-025 SHALL, while Stall is high and there is no redirect, never change Instr_ID, PC_plus4_ID or Valid_ID.
REQ-026 SHALL give a redirect priority over Stall and always set Valid_ID<=0 at the next edge (flush).
REQ-027 SHALL, on a redirect in FETCH with ready: discard the data; PC<=target; stay in FETCH.
REQ-028 SHALL, on a redirect in FETCH without ready: save the target in a pending register; next state DISCARD.
REQ-029 SHALL, on a redirect in HOLD: drop the buffer; PC<=target; next state FETCH.
REQ-030 SHALL, on a redirect in DISCARD: overwrite the pending target (newest wins).
REQ-031 SHALL, in DISCARD on ready: drop the data; PC<=pending target; next state FETCH.
REQ-032 SHALL, in DISCARD on ready coinciding with a new redirect: PC<=the new target.
REQ-033 SHALL compute PC+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-034 SHALL have zero latency: a word returned with ready in cycle N is visible on Instr_ID in cycle N+1, unless stalled or flushed.

Reset
REQ-035 SHALL, when rst_n=0 at a clock edge, set PC=RESET_PC, state=FETCH, Valid_ID=0, Instr_ID=0, PC_plus4_ID=0, pending target=0, and clear the hold buffer and counters.
REQ-036 SHALL force IMemReq=0 combinationally while rst_n=0.
REQ-037 SHALL let reset asserted mid-access (including in DISCARD) abandon the access; a late IMemReady SHALL be ignored while rst_n=0.

Configuration
REQ-038 SHALL, with macro FETCH_PERF_EN defined, increment FetchCount on each Valid_ID 0/1 load of a new instruction into IF/ID, increment FlushCount on each redirect cycle, and let both wrap at 2^32.
REQ-039 SHALL, without FETCH_PERF_EN, keep FetchCount and FlushCount present and tied to 0, with no counter flops.

Verification
REQ-040 SHALL cover: reset then ready every cycle -> IMemAddr 0,4,8,12; Valid_ID=1 from cycle 2; PC_plus4_ID 4,8,12.
REQ-041 SHALL cover: Stall=1 for 3 cycles with ready at the first -> HOLD entered, IMemReq=0, IF/ID unchanged; after Stall drops, the word appears once and is not refetched.
REQ-042 SHALL cover: PCSource=1 with PC_branch=32'h0000_0103 while the access is outstanding (ready 2 cycles later) -> old word dropped; next IMemAddr=32'h0000_0100; Valid_ID=0 for the flush.
REQ-043 SHALL cover: two redirects in DISCARD (jump to 0x200, then branch to 0x300) -> fetch resumes at 0x300.
REQ-044 SHALL cover: RESET_PC=32'hFFFF_FFFC with ready -> PC_plus4_ID=0; next IMemAddr=0.
REQ-045 SHALL cover: with FETCH_PERF_EN, 5 instructions and 2 redirects -> FetchCount=5, FlushCount=2; without the macro, both read 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// ----------------------------------------------------------------------------
// Instruction-fetch stage. It keeps the program counter, issues requests to
// instruction memory and fills the IF/ID pipeline register. It honours hazard
// stalls from the hazard unit and branch/jump redirects from later stages.
//
// A redirect (PCSource 1 or 2) takes priority over Stall and always flushes
// IF/ID (Valid_ID<=0) at the next edge.
//
// FSM states:
//   FETCH   - PC is on the bus. A returned word is accepted into IF/ID, or
//             parked in the hold buffer while stalled.
//   HOLD    - A word is parked while Stall is high. No request is issued.
//   DISCARD - A redirect arrived while an access was outstanding. The old
//             access runs to completion and its data is dropped; then fetch
//             resumes at the pending target.
//
// Handshake: IMemReq/IMemAddr form a request that is held stable until the
// cycle in which IMemReady is high. IMemData is valid only in that same
// cycle. No request is issued in HOLD or while rst_n is low.
//
// Ports:
//   clk, rst_n       rising-edge clock, synchronous active-low reset
//   PCSource[1:0]    0 seq, 1 branch, 2 jump, 3 reserved (acts as seq)
//   PC_branch[31:0]  branch target (bits [1:0] ignored)
//   PC_jump[31:0]    jump target (bits [1:0] ignored)
//   Stall            hold request for IF/ID
//   IMemReq          instruction-memory request
//   IMemAddr[31:0]   fetch address
//   IMemReady        access complete; IMemData valid this cycle
//   IMemData[31:0]   fetched word
//   Instr_ID[31:0]   IF/ID instruction
//   PC_plus4_ID      IF/ID fetch PC + 4
//   Valid_ID         IF/ID holds a real instruction
//   FetchCount       instructions loaded into IF/ID (FETCH_PERF_EN only)
//   FlushCount       redirect cycles (FETCH_PERF_EN only)
//   fsm_state[1:0]   debug view of the FSM: 0 FETCH, 1 DISCARD, 2 HOLD
//
// Configuration: define FETCH_PERF_EN to build the two performance counters.
// Without it, both counters read 0 and no counter flops are built.
// ----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  PCSource,
  input  logic [31:0] PC_branch,
  input  logic [31:0] PC_jump,
  input  logic        Stall,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] Instr_ID,
  output logic [31:0] PC_plus4_ID,
  output logic        Valid_ID,
  output logic [31:0] FetchCount,
  output logic [31:0] FlushCount,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend;
  logic [31:0] hold_buf;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  always_comb begin
    redirect = (PCSource == 2'd1) || (PCSource == 2'd2);
    target   = (PCSource == 2'd2) ? PC_jump : PC_branch;
    target   = target & 32'hFFFF_FFFC;
  end

  // Wraps naturally at 2^32.
  assign pc_plus4 = pc + 32'd4;

  // In DISCARD the PC is left untouched, so pc is still the outstanding
  // address and the bus stays stable until the access completes.
  assign IMemAddr  = pc;
  assign IMemReq   = rst_n && (state != HOLD);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      pend        <= 32'd0;
      hold_buf    <= 32'd0;
      Instr_ID    <= 32'd0;
      PC_plus4_ID <= 32'd0;
      Valid_ID    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            Valid_ID <= 1'b0;
            if (IMemReady) begin
              pc <= target;
            end else begin
              pend  <= target;
              state <= DISCARD;
            end
          end else if (IMemReady && !Stall) begin
            Instr_ID    <= IMemData;
            PC_plus4_ID <= pc_plus4;
            Valid_ID    <= 1'b1;
            pc          <= pc_plus4;
          end else if (IMemReady) begin
            // Stalled with a word in hand: park it, leave IF/ID alone.
            hold_buf <= IMemData;
            state    <= HOLD;
          end else if (!Stall) begin
            Valid_ID <= 1'b0;
          end
        end

        HOLD: begin
          if (redirect) begin
            Valid_ID <= 1'b0;
            pc       <= target;
            state    <= FETCH;
          end else if (!Stall) begin
            Instr_ID    <= hold_buf;
            PC_plus4_ID <= pc_plus4;
            Valid_ID    <= 1'b1;
            pc          <= pc_plus4;
            state       <= FETCH;
          end
        end

        DISCARD: begin
          if (redirect || !Stall) begin
            Valid_ID <= 1'b0;
          end
          if (IMemReady) begin
            // The newest redirect wins, even one landing on the ready cycle.
            pc    <= redirect ? target : pend;
            state <= FETCH;
          end else if (redirect) begin
            pend <= target;
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic fetch_load;

  always_comb begin
    fetch_load = 1'b0;
    if (!redirect && !Stall) begin
      fetch_load = ((state == FETCH) && IMemReady) || (state == HOLD);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      FetchCount <= 32'd0;
      FlushCount <= 32'd0;
    end else begin
      if (fetch_load) FetchCount <= FetchCount + 32'd1;
      if (redirect)   FlushCount <= FlushCount + 32'd1;
    end
  end
`else
  assign FetchCount = 32'd0;
  assign FlushCount = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit. A second instance with RESET_PC at the
// top of the address space covers PC+4 wrap-around. Memory data is a fixed
// function of the address (C0DE_0000 ^ addr), so expected words are
// hand-computed constants.
module tb_pc_fetch_unit;

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_DISCARD = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_source;
  logic [31:0] pc_branch;
  logic [31:0] pc_jump;
  logic        stall;
  logic        imem_ready;
  logic [31:0] imem_data;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr_id;
  logic [31:0] pc_plus4_id;
  logic        valid_id;
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
  logic [1:0]  fsm_state;

  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_instr_id;
  logic [31:0] w_pc_plus4_id;
  logic        w_valid_id;
  logic [31:0] w_fetch_count;
  logic [31:0] w_flush_count;
  logic [1:0]  w_fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  assign imem_data = 32'hC0DE_0000 ^ imem_addr;

  pc_fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .PCSource(pc_source), .PC_branch(pc_branch),
    .PC_jump(pc_jump), .Stall(stall), .IMemReq(imem_req), .IMemAddr(imem_addr),
    .IMemReady(imem_ready), .IMemData(imem_data), .Instr_ID(instr_id),
    .PC_plus4_ID(pc_plus4_id), .Valid_ID(valid_id), .FetchCount(fetch_count),
    .FlushCount(flush_count), .fsm_state(fsm_state)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .PCSource(pc_source), .PC_branch(pc_branch),
    .PC_jump(pc_jump), .Stall(stall), .IMemReq(w_imem_req), .IMemAddr(w_imem_addr),
    .IMemReady(imem_ready), .IMemData(imem_data), .Instr_ID(w_instr_id),
    .PC_plus4_ID(w_pc_plus4_id), .Valid_ID(w_valid_id), .FetchCount(w_fetch_count),
    .FlushCount(w_flush_count), .fsm_state(w_fsm_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic stl, input logic [1:0] src,
                       input logic [31:0] br, input logic [31:0] jp);
    imem_ready = rdy;
    stall      = stl;
    pc_source  = src;
    pc_branch  = br;
    pc_jump    = jp;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_fetch;
  logic [31:0] exp_flush;

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0);
    tick();
    tick();
    // Late ready while in reset must not start anything.
    check("req_in_reset", {31'd0, imem_req}, 32'd0);
    check("state_in_reset", {30'd0, fsm_state}, {30'd0, S_FETCH});

    rst_n = 1'b1;
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd1);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'd0, valid_id}, 32'd0);
    check("rst_instr", instr_id, 32'h0);
    check("rst_p4", pc_plus4_id, 32'h0);
    check("rst_wrap_addr", w_imem_addr, 32'hFFFF_FFFC);

    // ---- sequential fetch, ready every cycle ----
    tick();  // E1
    check("seq1_addr", imem_addr, 32'd4);
    check("seq1_valid", {31'd0, valid_id}, 32'd1);
    check("seq1_p4", pc_plus4_id, 32'd4);
    check("seq1_instr", instr_id, 32'hC0DE_0000);
    check("wrap_p4", w_pc_plus4_id, 32'd0);
    check("wrap_addr", w_imem_addr, 32'd0);
    check("wrap_valid", {31'd0, w_valid_id}, 32'd1);
    tick();  // E2
    check("seq2_addr", imem_addr, 32'd8);
    check("seq2_p4", pc_plus4_id, 32'd8);
    check("seq2_instr", instr_id, 32'hC0DE_0004);
    tick();  // E3
    check("seq3_addr", imem_addr, 32'd12);
    check("seq3_p4", pc_plus4_id, 32'd12);

    // ---- stall for 3 cycles, ready on the first ----
    drive(1'b1, 1'b1, 2'd0, 32'd0, 32'd0);
    tick();  // E4: word at 12 parked
    check("stall_state", {30'd0, fsm_state}, {30'd0, S_HOLD});
    check("stall_req", {31'd0, imem_req}, 32'd0);
    check("stall_instr", instr_id, 32'hC0DE_0008);
    check("stall_p4", pc_plus4_id, 32'd12);
    drive(1'b0, 1'b1, 2'd0, 32'd0, 32'd0);
    tick();  // E5
    tick();  // E6
    check("stall3_instr", instr_id, 32'hC0DE_0008);
    check("stall3_valid", {31'd0, valid_id}, 32'd1);
    check("stall3_addr", imem_addr, 32'd12);
    drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    tick();  // E7: parked word released
    check("release_instr", instr_id, 32'hC0DE_000C);
    check("release_p4", pc_plus4_id, 32'd16);
    check("release_valid", {31'd0, valid_id}, 32'd1);
    check("release_addr", imem_addr, 32'd16);
    check("release_state", {30'd0, fsm_state}, {30'd0, S_FETCH});
    tick();  // E8: bubble, no refetch of 12
    check("bubble_valid", {31'd0, valid_id}, 32'd0);
    check("bubble_addr", imem_addr, 32'd16);

    // ---- branch while access outstanding ----
    drive(1'b0, 1'b0, 2'd1, 32'h0000_0103, 32'd0);
    tick();  // E9
    check("br_state", {30'd0, fsm_state}, {30'd0, S_DISCARD});
    check("br_old_addr", imem_addr, 32'd16);
    check("br_req", {31'd0, imem_req}, 32'd1);
    check("br_flush", {31'd0, valid_id}, 32'd0);
    drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    tick();  // E10
    drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0);
    tick();  // E11: old word dropped
    check("br_target", imem_addr, 32'h0000_0100);
    check("br_drop_instr", instr_id, 32'hC0DE_000C);
    check("br_drop_valid", {31'd0, valid_id}, 32'd0);

    // ---- two redirects in DISCARD, newest wins ----
    drive(1'b0, 1'b0, 2'd2, 32'd0, 32'h0000_0200);
    tick();  // E12
    drive(1'b0, 1'b0, 2'd1, 32'h0000_0300, 32'd0);
    tick();  // E13
    check("dbl_state", {30'd0, fsm_state}, {30'd0, S_DISCARD});
    drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0);
    tick();  // E14
    check("dbl_addr", imem_addr, 32'h0000_0300);

    // ---- redirect coinciding with ready in DISCARD ----
    drive(1'b0, 1'b0, 2'd2, 32'd0, 32'h0000_0400);
    tick();  // E15
    drive(1'b1, 1'b0, 2'd1, 32'h0000_0500, 32'd0);
    tick();  // E16
    check("coin_addr", imem_addr, 32'h0000_0500);
    check("coin_valid", {31'd0, valid_id}, 32'd0);
    drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0);
    tick();  // E17
    check("coin_instr", instr_id, 32'hC0DE_0500);
    check("coin_p4", pc_plus4_id, 32'h0000_0504);

    // ---- jump with ready in FETCH: data discarded ----
    drive(1'b1, 1'b0, 2'd2, 32'd0, 32'h0000_0603);
    tick();  // E18
    check("jr_addr", imem_addr, 32'h0000_0600);
    check("jr_valid", {31'd0, valid_id}, 32'd0);
    check("jr_instr", instr_id, 32'hC0DE_0500);

    // ---- redirect in HOLD drops the buffer ----
    drive(1'b1, 1'b1, 2'd0, 32'd0, 32'd0);
    tick();  // E19
    drive(1'b0, 1'b1, 2'd1, 32'h0000_0700, 32'd0);
    tick();  // E20
    check("hr_state", {30'd0, fsm_state}, {30'd0, S_FETCH});
    check("hr_addr", imem_addr, 32'h0000_0700);
    check("hr_valid", {31'd0, valid_id}, 32'd0);
    drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0);
    tick();  // E21
    check("hr_instr", instr_id, 32'hC0DE_0700);
    check("hr_p4", pc_plus4_id, 32'h0000_0704);

`ifdef FETCH_PERF_EN
    exp_fetch = 32'd6;
    exp_flush = 32'd7;
`else
    exp_fetch = 32'd0;
    exp_flush = 32'd0;
`endif
    check("cnt_fetch_mid", fetch_count, exp_fetch);
    check("cnt_flush_mid", flush_count, exp_flush);

    // ---- reset in the middle of a DISCARD ----
    drive(1'b0, 1'b0, 2'd1, 32'h0000_0800, 32'd0);
    tick();  // E22
    check("pre_rst_state", {30'd0, fsm_state}, {30'd0, S_DISCARD});
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0);
    #1;
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    tick();  // E23
    check("mid_rst_state", {30'd0, fsm_state}, {30'd0, S_FETCH});
    check("mid_rst_addr", imem_addr, 32'd0);
    check("mid_rst_instr", instr_id, 32'd0);
    check("mid_rst_valid", {31'd0, valid_id}, 32'd0);
    check("mid_rst_fcnt", fetch_count, 32'd0);
    check("mid_rst_xcnt", flush_count, 32'd0);

    // ---- counters: 5 instructions then 2 redirects ----
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("perf_p4", pc_plus4_id, 32'd20);
    drive(1'b1, 1'b0, 2'd2, 32'd0, 32'h0000_0040);
    tick();
    drive(1'b1, 1'b0, 2'd1, 32'h0000_0080, 32'd0);
    tick();
    drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    check("perf_addr", imem_addr, 32'h0000_0080);
    check("perf_valid", {31'd0, valid_id}, 32'd0);
`ifdef FETCH_PERF_EN
    exp_fetch = 32'd5;
    exp_flush = 32'd2;
`else
    exp_fetch = 32'd0;
    exp_flush = 32'd0;
`endif
    check("perf_fetch", fetch_count, exp_fetch);
    check("perf_flush", flush_count, exp_flush);

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
